// File: rtl/cnn_pkg.sv
// Shared types and width helpers for the CNN frame sequencer slice.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT
    } state_t;

    // Wide enough for any digit width; users slice the low BCD_BITS.
    localparam logic [63:0] DIGIT_TIMEOUT_CODE = '1;

    function automatic int frame_pixels(input int dim);
        return dim * dim;
    endfunction

    // Bits needed to count 0..n-1, never less than 1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int timer_width(input int timeout);
        return cnt_width(timeout + 1);
    endfunction

    function automatic int frame_bits(input int max_frames);
        return $clog2(max_frames + 1);
    endfunction

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Pixel, CNN and result signals of the frame sequencer.
// master = sequencer side, slave = pixel source / CNN / result consumer side.
interface cnn_frame_sequencer_if #(
    parameter int GS_BITS    = 8,
    parameter int BCD_BITS   = 4,
    parameter int FRAME_BITS = 11
);
    logic [GS_BITS-1:0]    s_pixel;
    logic                  s_valid;
    logic                  s_ready;
    logic [GS_BITS-1:0]    pixel_o;
    logic                  pixel_o_valid;
    logic [BCD_BITS-1:0]   digit_i;
    logic                  digit_i_valid;
    logic [BCD_BITS-1:0]   res_digit;
    logic [FRAME_BITS-1:0] res_index;
    logic                  res_valid;
    logic                  res_timeout;

    modport master (
        input  s_pixel, s_valid, digit_i, digit_i_valid,
        output s_ready, pixel_o, pixel_o_valid,
               res_digit, res_index, res_valid, res_timeout
    );

    modport slave (
        output s_pixel, s_valid, digit_i, digit_i_valid,
        input  s_ready, pixel_o, pixel_o_valid,
               res_digit, res_index, res_valid, res_timeout
    );
endinterface

// File: rtl/mod_N_counter.sv
// Modulo-N up counter; done flags the terminal count N-1.
module mod_N_counter
    import cnn_pkg::*;
#(
    parameter int N = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int W = cnt_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;

    assign done = (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= done ? '0 : count_q + W'(1);
        end
    end
endmodule

// File: rtl/cnn_frame_sequencer.sv
// Streams IMG_DIM x IMG_DIM frames into the CNN and reports one result per
// frame (CNN digit or timeout code) tagged with its frame index.
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int GS_BITS    = 8,
    parameter int BCD_BITS   = 4,
    parameter int IMG_DIM    = 30,
    parameter int MAX_FRAMES = 1024,
    parameter int TIMEOUT    = 4096,
    localparam int FRAME_BITS = frame_bits(MAX_FRAMES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] num_frames,
    cnn_frame_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  spurious
);
    localparam int FRAME_PIXELS = frame_pixels(IMG_DIM);
    localparam int TIMER_W      = timer_width(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        (TIMEOUT == 0) ? '0 : TIMER_W'(TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] num_frames_q, frame_cnt_q;
    logic [TIMER_W-1:0]    timer_q;
    logic                  pix_last, last_frame, expire;
    logic                  accept, zero_start, xfer, finish, timed_out, spur_evt;

    logic [GS_BITS-1:0]    pixel_q;
    logic                  pixel_valid_q;
    logic [BCD_BITS-1:0]   res_digit_q;
    logic [FRAME_BITS-1:0] res_index_q;
    logic                  res_valid_q, res_timeout_q;
    logic                  done_q, spurious_q;

    mod_N_counter #(.N(FRAME_PIXELS)) u_pix_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (xfer),
        .done (pix_last)
    );

    assign last_frame = (frame_cnt_q == num_frames_q - FRAME_BITS'(1));
    assign expire     = TIMEOUT_EN && (timer_q == TIMER_LAST);
    assign spur_evt   = bus.digit_i_valid && (state_q != WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A digit and a timer expiry in the same WAIT cycle resolve to the digit.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        zero_start = 1'b0;
        xfer       = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_frames != '0) begin
                        accept  = 1'b1;
                        state_d = STREAM;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            STREAM: begin
                xfer = bus.s_valid;
                if (xfer && pix_last) state_d = WAIT;
            end
            WAIT: begin
                if (bus.digit_i_valid) begin
                    finish = 1'b1;
                end else if (expire) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end
                if (finish) state_d = last_frame ? IDLE : STREAM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_frames_q  <= '0;
            frame_cnt_q   <= '0;
            timer_q       <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            res_digit_q   <= '0;
            res_index_q   <= '0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            done_q        <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            if (accept) begin
                num_frames_q <= num_frames;
                frame_cnt_q  <= '0;
            end else if (finish && !last_frame) begin
                frame_cnt_q <= frame_cnt_q + FRAME_BITS'(1);
            end

            if (xfer && pix_last) begin
                timer_q <= '0;
            end else if (TIMEOUT_EN && state_q == WAIT) begin
                timer_q <= timer_q + TIMER_W'(1);
            end

            pixel_valid_q <= xfer;
            if (xfer) pixel_q <= bus.s_pixel;

            res_valid_q <= finish;
            if (finish) begin
                res_digit_q   <= timed_out ? DIGIT_TIMEOUT_CODE[BCD_BITS-1:0] : bus.digit_i;
                res_timeout_q <= timed_out;
                res_index_q   <= frame_cnt_q;
            end

            done_q     <= zero_start || (finish && last_frame);
            spurious_q <= (accept ? 1'b0 : spurious_q) || spur_evt;
        end
    end

    assign bus.s_ready       = (state_q == STREAM);
    assign bus.pixel_o       = pixel_q;
    assign bus.pixel_o_valid = pixel_valid_q;
    assign bus.res_digit     = res_digit_q;
    assign bus.res_index     = res_index_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_timeout   = res_timeout_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign spurious          = spurious_q;
endmodule
